// File: rtl/robo_action_sequencer.sv
// -----------------------------------------------------------------------------
// robo_action_sequencer
//
// Drives the wall-following robot FSM. It gives the robot FSM a one-cycle step
// enable, samples the command the FSM then presents, and plays that command out
// as a timed actuator pulse. Runs of turn commands with no forward move or
// removal in between are counted. A long run of them trips a sticky watchdog
// that holds the robot still until reset. Completed removals are counted.
//
// Ports
//   clock         in   1  system clock, rising edge
//   reset         in   1  asynchronous, active-high
//   cmd_avancar   in   1  robot FSM "advance" command (level)
//   cmd_girar     in   1  robot FSM "turn" command (level)
//   cmd_remover   in   1  robot FSM "remove" command (level)
//   step          out  1  one-cycle clock enable to the robot FSM state register
//   motor_fwd     out  1  forward drive enable
//   motor_turn    out  1  rotate drive enable
//   arm_on        out  1  removal arm enable
//   busy          out  1  an actuator action is in progress
//   done          out  1  one-cycle pulse after an action completes
//   stuck         out  1  watchdog tripped; sticky until reset
//   remove_count  out  8  completed removals, saturating at 255
// -----------------------------------------------------------------------------
module robo_action_sequencer #(
  parameter int T_MOVE      = 4,
  parameter int T_TURN      = 6,
  parameter int T_REMOVE    = 8,
  parameter int STUCK_LIMIT = 4,
  parameter int CNT_W       = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_avancar,
  input  logic       cmd_girar,
  input  logic       cmd_remover,
  output logic       step,
  output logic       motor_fwd,
  output logic       motor_turn,
  output logic       arm_on,
  output logic       busy,
  output logic       done,
  output logic       stuck,
  output logic [7:0] remove_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SAMPLE = 3'd1;
  localparam logic [2:0] MOVE   = 3'd2;
  localparam logic [2:0] TURN   = 3'd3;
  localparam logic [2:0] REMOVE = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  // Wide enough to hold STUCK_LIMIT itself: the run count reaches it exactly
  // on the sample that trips the watchdog.
  localparam int TR_W = $clog2(STUCK_LIMIT + 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] timer;
  logic [TR_W-1:0]  turn_run;
  logic [TR_W-1:0]  turn_next;

  assign turn_next = turn_run + TR_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      turn_run     <= '0;
      done         <= 1'b0;
      remove_count <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of state/timer/turn_run regardless of statement order.
      done <= 1'b0;
      case (state)
        IDLE: state <= SAMPLE;

        SAMPLE: begin
          // remover outranks girar, which outranks avancar.
          if (cmd_remover) begin
            state    <= REMOVE;
            timer    <= CNT_W'(T_REMOVE - 1);
            turn_run <= '0;
          end else if (cmd_girar) begin
            turn_run <= turn_next;
            if (turn_next == TR_W'(STUCK_LIMIT)) begin
              state <= HALT;
            end else begin
              state <= TURN;
              timer <= CNT_W'(T_TURN - 1);
            end
          end else if (cmd_avancar) begin
            state    <= MOVE;
            timer    <= CNT_W'(T_MOVE - 1);
            turn_run <= '0;
          end else begin
            // No command: robot is in Standby; re-step it without touching
            // the turn run.
            state <= IDLE;
          end
        end

        MOVE, TURN, REMOVE: begin
          // The timer is loaded with T_*-1 and the exit happens on the cycle
          // it reads zero, giving exactly T_* cycles in the action state.
          if (timer == '0) begin
            state <= IDLE;
            done  <= 1'b1;
            if (state == REMOVE && remove_count != 8'hFF) begin
              remove_count <= remove_count + 8'd1;
            end
          end else begin
            timer <= timer - CNT_W'(1);
          end
        end

        HALT:    state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

  // Actuators decode directly from the state register, so an async reset
  // drops them in the same cycle and at most one can ever be high.
  // step is also gated by reset so it stays low while reset is held.
  assign step       = (state == IDLE) && !reset;
  assign motor_fwd  = (state == MOVE);
  assign motor_turn = (state == TURN);
  assign arm_on     = (state == REMOVE);
  assign busy       = (state == MOVE) || (state == TURN) || (state == REMOVE);
  assign stuck      = (state == HALT);

endmodule
